// File: rtl/seq_accumulator.sv
// seq_accumulator: steps through a constant digit sequence and adds each
// digit into a running sum that either wraps or saturates. Tracks a sticky
// overflow flag, a one-cycle end-of-pass pulse and a saturating pass count.
// A small checker module holding the design invariants follows the top.

module seq_accumulator #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 8,
    parameter logic [DEPTH*DIGIT_W-1:0] SEQ = 32'h8702_3114
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     sat_mode,
    output logic [DIGIT_W-1:0]       digit,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic [WIDTH-1:0]         sum,
    output logic                     ovf,
    output logic                     seq_wrap,
    output logic [7:0]               pass_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [7:0]       PASS_MAX = 8'hFF;

    // Sequence lookup written as a compare loop so that non-power-of-two
    // DEPTH values never index past the end of SEQ.
    function automatic logic [DIGIT_W-1:0] digit_at(input logic [IDX_W-1:0] pos);
        logic [DIGIT_W-1:0] r;
        r = SEQ[DIGIT_W-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            if (pos == IDX_W'(i)) begin
                r = SEQ[i*DIGIT_W +: DIGIT_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0]   sum_r, sum_n_s;
    logic [IDX_W-1:0]   idx_r, idx_n_s;
    logic               ovf_r, ovf_n_s;
    logic               wrap_r, wrap_n_s;
    logic [7:0]         pass_r, pass_n_s;
    logic [DIGIT_W-1:0] digit_s;
    logic [WIDTH:0]     ext_s;

    // Current digit and the one-bit-wider sum used to detect carry out.
    always_comb begin
        digit_s = digit_at(idx_r);
        ext_s   = {1'b0, sum_r} + {{(WIDTH + 1 - DIGIT_W){1'b0}}, digit_s};
    end

    // Next-state logic: clr beats en, en beats hold.
    always_comb begin
        sum_n_s  = sum_r;
        idx_n_s  = idx_r;
        ovf_n_s  = ovf_r;
        wrap_n_s = 1'b0;
        pass_n_s = pass_r;
        if (clr) begin
            sum_n_s  = {WIDTH{1'b0}};
            idx_n_s  = {IDX_W{1'b0}};
            ovf_n_s  = 1'b0;
            pass_n_s = 8'h00;
        end else if (en) begin
            if (ext_s[WIDTH]) begin
                ovf_n_s = 1'b1;
                if (sat_mode) begin
                    sum_n_s = {WIDTH{1'b1}};
                end else begin
                    sum_n_s = ext_s[WIDTH-1:0];
                end
            end else begin
                sum_n_s = ext_s[WIDTH-1:0];
            end
            if (idx_r == LAST_IDX) begin
                idx_n_s  = {IDX_W{1'b0}};
                wrap_n_s = 1'b1;
                if (pass_r != PASS_MAX) begin
                    pass_n_s = pass_r + 8'd1;
                end else begin
                    pass_n_s = pass_r;
                end
            end else begin
                idx_n_s = idx_r + IDX_ONE;
            end
        end else begin
            sum_n_s = sum_r;
            idx_n_s = idx_r;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r  <= {WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            ovf_r  <= 1'b0;
            wrap_r <= 1'b0;
            pass_r <= 8'h00;
        end else begin
            sum_r  <= sum_n_s;
            idx_r  <= idx_n_s;
            ovf_r  <= ovf_n_s;
            wrap_r <= wrap_n_s;
            pass_r <= pass_n_s;
        end
    end

    assign digit    = digit_s;
    assign idx      = idx_r;
    assign sum      = sum_r;
    assign ovf      = ovf_r;
    assign seq_wrap = wrap_r;
    assign pass_cnt = pass_r;

    seq_accumulator_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .idx      (idx_r),
        .ovf      (ovf_r),
        .seq_wrap (wrap_r)
    );

endmodule

// Design invariants: index range, sticky overflow, single-cycle wrap pulse.
module seq_accumulator_chk #(
    parameter int DEPTH = 8
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     clr,
    input logic [$clog2(DEPTH)-1:0] idx,
    input logic                     ovf,
    input logic                     seq_wrap
);

    a_idx_range: assert property (@(posedge clk) disable iff (!reset)
        idx <= ($clog2(DEPTH))'(DEPTH - 1));

    a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset)
        (ovf && !clr) |=> ovf);

    a_wrap_pulse: assert property (@(posedge clk) disable iff (!reset)
        seq_wrap |=> !seq_wrap);

endmodule
